// File: rtl/pair_filter.sv
// Pair filter: pairs a held reference particle with a stream of neighbours on a
// fixed 16-slot frame and emits one pair word per cycle (invalid unless within cutoff).
module pair_filter #(
  parameter logic [67:0] CUTOFF_SQ = 68'd1048576,
  parameter int          LAT       = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ref_valid,
  output logic         ref_ready,
  input  logic [112:0] ref_data,
  input  logic         nbr_valid,
  output logic         nbr_ready,
  input  logic [112:0] nbr_data,
  input  logic         nbr_last,
  output logic [226:0] pair_out,
  output logic [3:0]   out_slot
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and there is no downstream stall.

  localparam logic [3:0]   SLOT_ADV = 4'(LAT);
  localparam logic [226:0] INVALID  = {1'b1, 226'b0};

  logic [3:0]   slot_q, slot_d;
  logic [3:0]   in_slot;
  logic         held_q, held_d;
  logic         done_q, done_d;
  logic [112:0] ref_q, ref_d;
  logic         ref_hs, nbr_hs;

  logic                s1_v_q, s1_v_d;
  logic [112:0]        s1_ref_q, s1_ref_d;
  logic [112:0]        s1_nbr_q, s1_nbr_d;
  logic signed [32:0]  s1_dx_q, s1_dx_d;
  logic signed [32:0]  s1_dy_q, s1_dy_d;
  logic signed [32:0]  s1_dz_q, s1_dz_d;

  logic                s2_v_q, s2_v_d;
  logic [112:0]        s2_ref_q, s2_ref_d;
  logic [112:0]        s2_nbr_q, s2_nbr_d;
  logic [65:0]         s2_sx_q, s2_sx_d;
  logic [65:0]         s2_sy_q, s2_sy_d;
  logic [65:0]         s2_sz_q, s2_sz_d;

  logic signed [65:0]  dx_ext, dy_ext, dz_ext;
  logic [67:0]         r2;
  logic                pair_ok;
  logic [226:0]        pair_q, pair_d;

  // The input side runs LAT slots ahead so results land in the slot they were accepted in.
  assign in_slot   = slot_q + SLOT_ADV;
  assign ref_ready = !reset && (in_slot == 4'd15) && (!held_q || done_q);
  assign nbr_ready = !reset && (in_slot <= 4'd13) && held_q && !done_q;
  assign ref_hs    = ref_valid && ref_ready;
  assign nbr_hs    = nbr_valid && nbr_ready;

  assign dx_ext = {{33{s1_dx_q[32]}}, s1_dx_q};
  assign dy_ext = {{33{s1_dy_q[32]}}, s1_dy_q};
  assign dz_ext = {{33{s1_dz_q[32]}}, s1_dz_q};

  always_comb begin
    slot_d = slot_q + 4'd1;
    held_d = held_q;
    done_d = done_q;
    ref_d  = ref_q;
    if (ref_hs) begin
      ref_d  = ref_data;
      held_d = 1'b1;
      done_d = 1'b0;
    end else if ((in_slot == 4'd15) && done_q) begin
      held_d = 1'b0;
      done_d = 1'b0;
    end
    if (nbr_hs && nbr_last) done_d = 1'b1;

    // Stage 1: 33-bit differences so extreme coordinates cannot wrap.
    s1_v_d   = nbr_hs;
    s1_ref_d = ref_q;
    s1_nbr_d = nbr_data;
    s1_dx_d  = {ref_q[95], ref_q[95:64]} - {nbr_data[95], nbr_data[95:64]};
    s1_dy_d  = {ref_q[63], ref_q[63:32]} - {nbr_data[63], nbr_data[63:32]};
    s1_dz_d  = {ref_q[31], ref_q[31:0]}  - {nbr_data[31], nbr_data[31:0]};

    // Stage 2: exact squares; the largest (2^32)^2 fits in 66 bits.
    s2_v_d   = s1_v_q;
    s2_ref_d = s1_ref_q;
    s2_nbr_d = s1_nbr_q;
    s2_sx_d  = 66'(dx_ext * dx_ext);
    s2_sy_d  = 66'(dy_ext * dy_ext);
    s2_sz_d  = 66'(dz_ext * dz_ext);

    // Stage 3: sum, cutoff and self-pair rejection.
    r2      = {2'b00, s2_sx_q} + {2'b00, s2_sy_q} + {2'b00, s2_sz_q};
    pair_ok = s2_v_q && (r2 <= CUTOFF_SQ) && (s2_ref_q[112:96] != s2_nbr_q[112:96]);
    pair_d  = INVALID;
    if (pair_ok) begin
      pair_d = {1'b0, s2_ref_q[112:96], s2_nbr_q[112:96], s2_ref_q[95:0], s2_nbr_q[95:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= 4'd15;
      held_q <= 1'b0;
      done_q <= 1'b0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      pair_q <= INVALID;
    end else begin
      slot_q <= slot_d;
      held_q <= held_d;
      done_q <= done_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      pair_q <= pair_d;
    end
  end

  always_ff @(posedge clk) begin
    ref_q    <= ref_d;
    s1_ref_q <= s1_ref_d;
    s1_nbr_q <= s1_nbr_d;
    s1_dx_q  <= s1_dx_d;
    s1_dy_q  <= s1_dy_d;
    s1_dz_q  <= s1_dz_d;
    s2_ref_q <= s2_ref_d;
    s2_nbr_q <= s2_nbr_d;
    s2_sx_q  <= s2_sx_d;
    s2_sy_q  <= s2_sy_d;
    s2_sz_q  <= s2_sz_d;
  end

  assign pair_out = pair_q;
  assign out_slot = slot_q;

endmodule

// File: tb/tb_pair_filter.sv
// Bench for pair_filter: directed particles with hand-decided validity; a monitor
// compares every output cycle against a queue of expected words with due cycles.
module tb_pair_filter;

  localparam logic [226:0] INV = {1'b1, 226'b0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ref_valid = 1'b0;
  logic [112:0] ref_data = '0;
  logic         nbr_valid = 1'b0;
  logic [112:0] nbr_data = '0;
  logic         nbr_last = 1'b0;
  logic         ref_ready, nbr_ready;
  logic [226:0] pair_out;
  logic [3:0]   out_slot;

  pair_filter dut (
    .clk(clk), .reset(reset),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data),
    .nbr_valid(nbr_valid), .nbr_ready(nbr_ready), .nbr_data(nbr_data),
    .nbr_last(nbr_last), .pair_out(pair_out), .out_slot(out_slot)
  );

  // clock/reset block and frame model
  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [3:0]   slot_m = 4'd15;
  bit           mon_en = 1'b0;
  logic [112:0] cur_ref = '0;
  logic [226:0] exp_q[$];
  int           due_q[$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    slot_m <= reset ? 4'd15 : slot_m + 4'd1;
  end

  function automatic logic [3:0] in_m();
    return slot_m + 4'd3;
  endfunction

  task automatic chk(input string name, input logic [226:0] act, input logic [226:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("out_slot", 227'(out_slot), 227'(slot_m));
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        chk("pair_word", pair_out, exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        chk("idle_invalid", pair_out, INV);
      end
    end
  end

  // driver tasks (all run at the falling edge)
  task automatic send_ref(input logic [16:0] tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z);
    ref_data  = {tag, x, y, z};
    ref_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("ref_ready", 227'(ref_ready), 227'(in_m() == 4'd15));
      if (in_m() == 4'd15) break;
      @(negedge clk);
    end
    cur_ref = {tag, x, y, z};
    @(negedge clk);
    ref_valid = 1'b0;
  endtask

  task automatic send_nbr(input logic [16:0] tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input bit last, input bit exp_v, input bit push);
    nbr_data  = {tag, x, y, z};
    nbr_last  = last;
    nbr_valid = 1'b1;
    for (int i = 0; i < 3 && in_m() > 4'd13; i++) begin
      chk("nbr_ready_gap", 227'(nbr_ready), 227'(0));
      @(negedge clk);
    end
    chk("nbr_ready", 227'(nbr_ready), 227'(1));
    if (push) begin
      exp_q.push_back(exp_v ? {1'b0, cur_ref[112:96], tag, cur_ref[95:0], x, y, z} : INV);
      due_q.push_back(cyc + 3);
    end
    @(negedge clk);
    nbr_valid = 1'b0;
    nbr_last  = 1'b0;
  endtask

  task automatic wait_in(input logic [3:0] s);
    for (int i = 0; i < 20 && in_m() != s; i++) @(negedge clk);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("ref_ready_idle", 227'(ref_ready), 227'(in_m() == 4'd15));
      chk("nbr_ready_idle", 227'(nbr_ready), 227'(0));
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) begin
      chk("ref_ready_rst", 227'(ref_ready), 227'(0));
      chk("nbr_ready_rst", 227'(nbr_ready), 227'(0));
      @(negedge clk);
    end
    reset = 1'b0;

    // alignment: one idle frame and a bit
    idle_check(18);

    // single pair, r2 = 1000000
    send_ref(17'd1, 32'd0, 32'd0, 32'd0);
    send_nbr(17'd2, 32'd1000, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);

    // cutoff boundary: 1024^2 valid, 1025^2 invalid, (-1024)^2 valid
    send_ref(17'd3, 32'd0, 32'd0, 32'd0);
    send_nbr(17'd10, 32'd1024, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    send_nbr(17'd11, 32'd1025, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    send_nbr(17'd12, -32'sd1024, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);

    // self-pair rejected, close distinct neighbour accepted
    send_ref(17'd5, 32'd100, -32'sd200, 32'd300);
    send_nbr(17'd5, 32'd100, -32'sd200, 32'd300, 1'b0, 1'b0, 1'b1);
    send_nbr(17'd6, 32'd100, -32'sd200, 32'd301, 1'b1, 1'b1, 1'b1);

    // coordinate wrap must stay far; a bubble must not pull the next pair earlier
    send_ref(17'd7, 32'h7FFF_FFFF, 32'd0, 32'd0);
    send_nbr(17'd8, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    send_nbr(17'd9, 32'h7FFF_FFFF, 32'd5, 32'd0, 1'b1, 1'b1, 1'b1);

    // spill: 16 neighbours with gaps at slots 3 and 7 of the first frame
    send_ref(17'd20, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 16; k++) begin
      if (k < 12 && (in_m() == 4'd3 || in_m() == 4'd7)) @(negedge clk);
      send_nbr(17'(100 + k), 32'(k * 10), -32'(k), 32'd3, k == 15, 1'b1, 1'b1);
    end
    // second reference offered at once, accepted only at the frame end
    send_ref(17'd21, 32'd0, 32'd0, 32'd0);
    send_nbr(17'd30, 32'd0, 32'd0, -32'sd500, 1'b1, 1'b1, 1'b1);

    // reset mid-frame with two pairs in flight: nothing may emerge
    send_ref(17'd40, 32'd0, 32'd0, 32'd0);
    wait_in(4'd6);
    send_nbr(17'd41, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    send_nbr(17'd42, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("ref_ready_midrst", 227'(ref_ready), 227'(0));
    chk("nbr_ready_midrst", 227'(nbr_ready), 227'(0));
    @(negedge clk);
    reset = 1'b0;
    idle_check(20);

    repeat (8) @(negedge clk);
    chk("scoreboard_drained", 227'(exp_q.size()), 227'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pair_filter.md
PAIR_FILTER -- requirements
Module: pair_filter

Interface
REQ-001 Parameter CUTOFF_SQ, default 68'd1048576: squared cutoff distance, unsigned 68-bit.
REQ-002 Parameter LAT, default 3: pipeline depth in cycles, fixed; other values are not supported.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 ref_valid  input  1  reference particle offered.
REQ-006 ref_ready  output  1  reference particle accepted this cycle when high with ref_valid.
REQ-007 ref_data  input  113  [112:96] tag; [95:64] x; [63:32] y; [31:0] z; positions are signed 32-bit.
REQ-008 nbr_valid  input  1  neighbour particle offered.
REQ-009 nbr_ready  output  1  neighbour accepted this cycle when high with nbr_valid.
REQ-010 nbr_data  input  113  same layout as ref_data.
REQ-011 nbr_last  input  1  qualifies nbr_data; marks the final neighbour for the held reference.
REQ-012 pair_out  output  227  pair word to the pair queue; layout in REQ-020.
REQ-013 out_slot  output  4  current output slot, for alignment checking.

Function
REQ-014 The block runs a 16-slot frame: out_slot increments by 1 every cycle and wraps 15->0.
REQ-015 in_slot is internal and always equals (out_slot+3) mod 16.
REQ-016 ref_ready is high only when in_slot==15 and no reference is held; a handshake at that edge loads ref_data and sets held.
REQ-017 nbr_ready is high only when in_slot is 0..13, a reference is held, and its done flag is clear.
REQ-018 In slots 14 and 15, nbr_ready is low and nbr_valid is ignored.
REQ-019 Accepting a neighbour with nbr_last=1 sets done; at the next in_slot==15 the reference is released (held cleared), and a new reference can be accepted at that same edge.
REQ-020 Pair word layout:
- [226] invalid
- [225:209] reference tag
- [208:192] neighbour tag
- [191:96] reference x,y,z
- [95:0] neighbour x,y,z
REQ-021 Pipeline stage 1: dx, dy, dz = ref - nbr, computed as 33-bit signed.
REQ-022 Pipeline stage 2: squares, 66-bit unsigned each.
REQ-023 Pipeline stage 3: 68-bit sum r2, then registered to pair_out.
REQ-024 Latency: a neighbour accepted at in_slot s appears on pair_out exactly 3 cycles later, at out_slot s (s = 0..13).
REQ-025 pair_out[226] = 0 only if the slot's neighbour was accepted, r2 <= CUTOFF_SQ, and the neighbour tag differs from the reference tag; otherwise 1.
REQ-026 When pair_out[226]=1, pair_out[225:0] = 0.
REQ-027 Output slots 14 and 15 always carry invalid words.
REQ-028 A slot in 0..13 with no handshake carries an invalid word; bubbles never shift later neighbours to earlier slots.
REQ-029 A reference with more than 14 neighbours spills into subsequent frames; slot order follows acceptance order.
REQ-030 No stall input: the downstream stage must accept one word per cycle.

Reset
REQ-031 While reset is high, at each clock edge:
- out_slot <= 15, so in_slot = 2
- held, done and all pipeline valid bits are cleared
- pair_out = {1'b1, 226'b0}
REQ-032 While reset is high, ref_ready and nbr_ready are 0.
REQ-033 Reset asserted mid-frame discards the held reference and all in-flight pairs; no valid word appears until a new reference and neighbour complete the pipeline.
REQ-034 After reset deassertion, the first out_slot value is 0, aligned with a pair queue reset on the same edge.

Verification
REQ-035 Alignment: reset, then idle -> out_slot sequence 15,0,1,...,15,0; pair_out[226]=1 every cycle; ref_ready high once per frame, when out_slot==12.
REQ-036 Single pair:
- stimulus: ref tag 1 at (0,0,0); neighbour tag 2 at (1000,0,0) with nbr_last, accepted at in_slot 0
- response: valid word at out_slot 0; [225:209]=1, [208:192]=2; all other slots invalid
REQ-037 Cutoff boundary:
- stimulus: neighbours at (1024,0,0), (1025,0,0), (-1024,0,0) in slots 0..2
- response: slots 0 and 2 valid; slot 1 invalid (r2=1050625 > 1048576)
REQ-038 Self-pair and wrap:
- stimulus: neighbour with the reference's own tag at identical position; also ref (0x7FFFFFFF,0,0) with neighbour (0x80000000,0,0)
- response: self-pair invalid; wrap pair invalid (33-bit dx = 2^32-1, no overflow wrap to a small distance)
REQ-039 Spill and back-to-back references:
- stimulus: 16 neighbours, gaps at slots 3 and 7, nbr_last on the 16th; a second reference offered immediately
- response: first frame has valid words in slots 0..13 except 3 and 7; remaining 4 neighbours land in slots 0..3 of the next frame; the second reference is loaded at the end of that frame
REQ-040 Reset mid-frame: assert reset at out_slot 5 with 2 pairs in flight -> no valid word emerges; out_slot reads 15 then 0 after deassertion; ref_ready stays low until in_slot 15.
